// File: rtl/ttt_pkg.sv
// Shared tic-tac-toe definitions.
// The game controller and the board/LED display stage both import this package,
// so cell encodings and state codes live here and only here.
package ttt_pkg;

    // Cell and side-to-move encodings as seen on pos1..pos9 and who
    localparam logic [1:0] CELL_EMPTY = 2'b00;
    localparam logic [1:0] CELL_X     = 2'b01;
    localparam logic [1:0] CELL_O     = 2'b10;
    localparam logic [1:0] WHO_DRAW   = 2'b11;

    localparam logic [3:0] MAX_MOVES  = 4'd9;

    typedef enum logic [1:0] {
        ST_PLAY  = 2'b00,
        ST_CHECK = 2'b01,
        ST_WIN   = 2'b10,
        ST_DRAW  = 2'b11
    } state_t;

    // Owner of a three-cell line, or CELL_EMPTY when the line is not complete
    function automatic logic [1:0] line_owner(input logic [1:0] a,
                                              input logic [1:0] b,
                                              input logic [1:0] c);
        if ((a != CELL_EMPTY) && (a == b) && (a == c))
            return a;
        else
            return CELL_EMPTY;
    endfunction

    function automatic logic [1:0] other_player(input logic [1:0] p);
        return (p == CELL_X) ? CELL_O : CELL_X;
    endfunction

endpackage

// File: rtl/ttt_win_detect.sv
// Combinational three-in-a-row detector.
// Ports:
//   board  in   18  cell k (1..9) occupies board[2k-1:2k-2]
//   win    out  1   some row, column or diagonal holds three equal non-empty cells
//   winner out  2   owner of the first completed line found, CELL_EMPTY if none
module ttt_win_detect
    import ttt_pkg::*;
(
    input  logic [17:0] board,
    output logic        win,
    output logic [1:0]  winner
);

    logic [1:0] c     [9];
    logic [1:0] owner [8];

    for (genvar k = 0; k < 9; k++) begin : g_cell
        assign c[k] = board[2*k +: 2];
    end

    assign owner[0] = line_owner(c[0], c[1], c[2]);
    assign owner[1] = line_owner(c[3], c[4], c[5]);
    assign owner[2] = line_owner(c[6], c[7], c[8]);
    assign owner[3] = line_owner(c[0], c[3], c[6]);
    assign owner[4] = line_owner(c[1], c[4], c[7]);
    assign owner[5] = line_owner(c[2], c[5], c[8]);
    assign owner[6] = line_owner(c[0], c[4], c[8]);
    assign owner[7] = line_owner(c[2], c[4], c[6]);

    // Play stops at the first completed line, so any lines complete at the same
    // time necessarily share one owner; picking the first is sufficient.
    always_comb begin
        win    = 1'b0;
        winner = CELL_EMPTY;
        for (int i = 0; i < 8; i++) begin
            if (!win && (owner[i] != CELL_EMPTY)) begin
                win    = 1'b1;
                winner = owner[i];
            end
        end
    end

endmodule

// File: rtl/ttt_game_ctrl.sv
// Tic-tac-toe game controller feeding the board/LED display stage.
// Owns the board, alternates players, rejects illegal moves, detects win/draw.
// Ports:
//   clk        in   1   system clock
//   rst_n      in   1   asynchronous active-low reset
//   new_game   in   1   pulse: clear board and restart (wins over move_vld)
//   move_vld   in   1   pulse: move request
//   move_pos   in   4   target cell 1..9, row-major from top-left
//   pos1..pos9 out  2   cell contents: 00 empty, 01 X, 10 O
//   who        out  2   side to move while playing; winner or 11 (draw) when over
//   ill        out  1   illegal-move indicator
//   game_over  out  1   game finished (win or draw)
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_PLAY  | waiting for a move from the side in who
// ST_CHECK | one cycle: judge the freshly written board, pick next state
// ST_WIN   | line completed; board and who (winner) frozen
// ST_DRAW  | ninth move without a line; board frozen, who = 11
module ttt_game_ctrl
    import ttt_pkg::*;
#(
    parameter logic [1:0]  FIRST_PLAYER = 2'b01,
    parameter logic [23:0] ILL_HOLD     = 24'd50_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       new_game,
    input  logic       move_vld,
    input  logic [3:0] move_pos,
    output logic [1:0] pos1,
    output logic [1:0] pos2,
    output logic [1:0] pos3,
    output logic [1:0] pos4,
    output logic [1:0] pos5,
    output logic [1:0] pos6,
    output logic [1:0] pos7,
    output logic [1:0] pos8,
    output logic [1:0] pos9,
    output logic [1:0] who,
    output logic       ill,
    output logic       game_over
);

    state_t      state, state_nxt;
    logic [17:0] board, board_nxt;
    logic [3:0]  move_cnt, move_cnt_nxt;
    logic [1:0]  who_nxt;
    logic        ill_nxt;
    logic [23:0] hold_cnt, hold_cnt_nxt;

    logic [1:0]  target;
    logic        line_win;
    logic [1:0]  line_winner;

    ttt_win_detect u_win_detect (
        .board  (board),
        .win    (line_win),
        .winner (line_winner)
    );

    // Contents of the requested cell; out-of-range positions read as 11 so
    // they fail the same "cell must be empty" test as occupied cells.
    always_comb begin
        target = 2'b11;
        for (int k = 0; k < 9; k++) begin
            if (move_pos == 4'(k + 1))
                target = board[2*k +: 2];
        end
    end

    always_comb begin
        state_nxt    = state;
        board_nxt    = board;
        move_cnt_nxt = move_cnt;
        who_nxt      = who;
        ill_nxt      = ill;
        hold_cnt_nxt = hold_cnt;

        // ill timeout: terminal count at 1 so ill is high for exactly ILL_HOLD cycles
        if ((ILL_HOLD != 24'd0) && ill) begin
            if (hold_cnt <= 24'd1) begin
                ill_nxt      = 1'b0;
                hold_cnt_nxt = 24'd0;
            end else begin
                hold_cnt_nxt = hold_cnt - 24'd1;
            end
        end

        case (state)
            ST_PLAY: begin
                if (move_vld) begin
                    if (target == CELL_EMPTY) begin
                        for (int k = 0; k < 9; k++) begin
                            if (move_pos == 4'(k + 1))
                                board_nxt[2*k +: 2] = who;
                        end
                        move_cnt_nxt = (move_cnt == MAX_MOVES) ? move_cnt : move_cnt + 4'd1;
                        ill_nxt      = 1'b0;
                        hold_cnt_nxt = 24'd0;
                        state_nxt    = ST_CHECK;
                    end else begin
                        ill_nxt      = 1'b1;
                        hold_cnt_nxt = ILL_HOLD;
                    end
                end
            end
            ST_CHECK: begin
                // Win is tested before the move count so a ninth-move win is a win
                if (line_win) begin
                    state_nxt = ST_WIN;
                    who_nxt   = line_winner;
                end else if (move_cnt == MAX_MOVES) begin
                    state_nxt = ST_DRAW;
                    who_nxt   = WHO_DRAW;
                end else begin
                    state_nxt = ST_PLAY;
                    who_nxt   = other_player(who);
                end
            end
            ST_WIN, ST_DRAW: begin
                state_nxt = state;
            end
            default: begin
                state_nxt = ST_PLAY;
            end
        endcase

        if (new_game) begin
            state_nxt    = ST_PLAY;
            board_nxt    = '0;
            move_cnt_nxt = 4'd0;
            who_nxt      = FIRST_PLAYER;
            ill_nxt      = 1'b0;
            hold_cnt_nxt = 24'd0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_PLAY;
            board    <= '0;
            move_cnt <= 4'd0;
            who      <= FIRST_PLAYER;
            ill      <= 1'b0;
            hold_cnt <= 24'd0;
        end else begin
            state    <= state_nxt;
            board    <= board_nxt;
            move_cnt <= move_cnt_nxt;
            who      <= who_nxt;
            ill      <= ill_nxt;
            hold_cnt <= hold_cnt_nxt;
        end
    end

    assign pos1 = board[1:0];
    assign pos2 = board[3:2];
    assign pos3 = board[5:4];
    assign pos4 = board[7:6];
    assign pos5 = board[9:8];
    assign pos6 = board[11:10];
    assign pos7 = board[13:12];
    assign pos8 = board[15:14];
    assign pos9 = board[17:16];

    assign game_over = (state == ST_WIN) || (state == ST_DRAW);

endmodule

// File: tb/tb_ttt_game_ctrl.sv
// Directed bench for ttt_game_ctrl with a short ill hold time.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_ttt_game_ctrl;

    localparam logic [1:0] E = 2'b00;
    localparam logic [1:0] X = 2'b01;
    localparam logic [1:0] O = 2'b10;
    localparam logic [1:0] D = 2'b11;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       new_game;
    logic       move_vld;
    logic [3:0] move_pos;
    logic [1:0] pos1, pos2, pos3, pos4, pos5, pos6, pos7, pos8, pos9;
    logic [1:0] who;
    logic       ill;
    logic       game_over;

    int total    = 0;
    int pass_cnt = 0;
    int fail_cnt = 0;

    ttt_game_ctrl #(
        .FIRST_PLAYER (2'b01),
        .ILL_HOLD     (24'd4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .new_game  (new_game),
        .move_vld  (move_vld),
        .move_pos  (move_pos),
        .pos1      (pos1),
        .pos2      (pos2),
        .pos3      (pos3),
        .pos4      (pos4),
        .pos5      (pos5),
        .pos6      (pos6),
        .pos7      (pos7),
        .pos8      (pos8),
        .pos9      (pos9),
        .who       (who),
        .ill       (ill),
        .game_over (game_over)
    );

    always #5 clk = ~clk;

    function automatic logic [17:0] cells(input logic [1:0] c1, input logic [1:0] c2,
                                          input logic [1:0] c3, input logic [1:0] c4,
                                          input logic [1:0] c5, input logic [1:0] c6,
                                          input logic [1:0] c7, input logic [1:0] c8,
                                          input logic [1:0] c9);
        return {c9, c8, c7, c6, c5, c4, c3, c2, c1};
    endfunction

    function automatic logic [17:0] brd();
        return {pos9, pos8, pos7, pos6, pos5, pos4, pos3, pos2, pos1};
    endfunction

    task automatic chk(input string tag, input logic [17:0] obs, input logic [17:0] exp);
        total++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One move pulse; returns on the falling edge after the sampling edge
    task automatic move(input logic [3:0] p);
        move_vld = 1'b1;
        move_pos = p;
        @(negedge clk);
        move_vld = 1'b0;
        move_pos = 4'd0;
    endtask

    // Move plus the CHECK cycle, so who/game_over are settled on return
    task automatic play(input logic [3:0] p);
        move(p);
        @(negedge clk);
    endtask

    task automatic restart();
        new_game = 1'b1;
        @(negedge clk);
        new_game = 1'b0;
    endtask

    initial begin
        rst_n    = 1'b0;
        new_game = 1'b0;
        move_vld = 1'b0;
        move_pos = 4'd0;
        repeat (2) @(negedge clk);

        chk("rst_board", brd(), 18'd0);
        chk("rst_who", 18'(who), 18'(X));
        chk("rst_ill", 18'(ill), 18'd0);
        chk("rst_go", 18'(game_over), 18'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Row 1-2-3 win for X, with latency checks on the first move
        move(4'd1);
        chk("t1_pos_latency", brd(), cells(X, E, E, E, E, E, E, E, E));
        chk("t1_who_not_yet", 18'(who), 18'(X));
        @(negedge clk);
        chk("t1_who_toggled", 18'(who), 18'(O));
        play(4'd4);
        play(4'd2);
        play(4'd5);
        move(4'd3);
        chk("t1_go_in_check", 18'(game_over), 18'd0);
        @(negedge clk);
        chk("t1_board", brd(), cells(X, X, X, O, O, E, E, E, E));
        chk("t1_who_winner", 18'(who), 18'(X));
        chk("t1_go", 18'(game_over), 18'd1);
        move(4'd6);
        @(negedge clk);
        chk("t1_frozen_board", brd(), cells(X, X, X, O, O, E, E, E, E));
        chk("t1_frozen_ill", 18'(ill), 18'd0);
        chk("t1_frozen_who", 18'(who), 18'(X));
        restart();
        chk("ng_board", brd(), 18'd0);
        chk("ng_who", 18'(who), 18'(X));
        chk("ng_go", 18'(game_over), 18'd0);

        // Occupied cell
        play(4'd5);
        move(4'd5);
        chk("t2_board", brd(), cells(E, E, E, E, X, E, E, E, E));
        chk("t2_ill", 18'(ill), 18'd1);
        chk("t2_who", 18'(who), 18'(O));
        move(4'd1);
        chk("t2_ill_clr", 18'(ill), 18'd0);
        chk("t2_board2", brd(), cells(O, E, E, E, X, E, E, E, E));
        @(negedge clk);
        chk("t2_who2", 18'(who), 18'(X));
        restart();

        // Out of range positions and hold-timer reload
        move(4'd0);
        chk("t3_ill_pos0", 18'(ill), 18'd1);
        repeat (2) @(negedge clk);
        move(4'd12);
        chk("t3_ill_pos12", 18'(ill), 18'd1);
        chk("t3_board", brd(), 18'd0);
        chk("t3_who", 18'(who), 18'(X));
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            chk($sformatf("t3_ill_hold%0d", k), 18'(ill), 18'd1);
        end
        @(negedge clk);
        chk("t3_ill_drop", 18'(ill), 18'd0);

        // Move request during CHECK is dropped
        move_vld = 1'b1;
        move_pos = 4'd5;
        @(negedge clk);
        move_pos = 4'd1;
        @(negedge clk);
        move_vld = 1'b0;
        move_pos = 4'd0;
        chk("t3b_board", brd(), cells(E, E, E, E, X, E, E, E, E));
        chk("t3b_ill", 18'(ill), 18'd0);
        chk("t3b_who", 18'(who), 18'(O));
        restart();

        // Full-board draw
        play(4'd1); play(4'd2); play(4'd3); play(4'd5); play(4'd4);
        play(4'd6); play(4'd8); play(4'd7); play(4'd9);
        chk("t4_board", brd(), cells(X, O, X, X, O, O, O, X, X));
        chk("t4_who", 18'(who), 18'(D));
        chk("t4_go", 18'(game_over), 18'd1);
        play(4'd5);
        chk("t4_after_board", brd(), cells(X, O, X, X, O, O, O, X, X));
        chk("t4_after_ill", 18'(ill), 18'd0);
        chk("t4_after_who", 18'(who), 18'(D));
        restart();

        // Ninth-move win: X completes column 3-6-9
        play(4'd1); play(4'd2); play(4'd3); play(4'd5); play(4'd6);
        play(4'd4); play(4'd8);
        play(4'd7);
        chk("t5_pre_go", 18'(game_over), 18'd0);
        play(4'd9);
        chk("t5_board", brd(), cells(X, O, X, O, O, X, O, X, X));
        chk("t5_who", 18'(who), 18'(X));
        chk("t5_go", 18'(game_over), 18'd1);
        restart();

        // new_game beats a simultaneous move, then reset during CHECK
        play(4'd1);
        play(4'd5);
        new_game = 1'b1;
        move_vld = 1'b1;
        move_pos = 4'd9;
        @(negedge clk);
        new_game = 1'b0;
        move_vld = 1'b0;
        move_pos = 4'd0;
        chk("t6_ng_board", brd(), 18'd0);
        chk("t6_ng_who", 18'(who), 18'(X));
        chk("t6_ng_ill", 18'(ill), 18'd0);
        move(4'd3);
        chk("t6_written", brd(), cells(E, E, X, E, E, E, E, E, E));
        rst_n = 1'b0;
        #1;
        chk("t6_rst_async", brd(), 18'd0);
        @(negedge clk);
        rst_n = 1'b1;
        chk("t6_rst_board", brd(), 18'd0);
        chk("t6_rst_who", 18'(who), 18'(X));
        chk("t6_rst_go", 18'(game_over), 18'd0);
        @(negedge clk);
        chk("t6_settled_who", 18'(who), 18'(X));
        play(4'd3);
        chk("t6_post_board", brd(), cells(E, E, X, E, E, E, E, E, E));
        chk("t6_post_who", 18'(who), 18'(O));

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
